fir_mac_datapath: RTL and testbench

// - Arithmetic half of the FIR filter; sits directly downstream of the FIR sequencer FSM (CONTROL).
// - Stores incoming samples in a circular delay line and reads coefficient[addr] from a ROM.
// - Forms coefficient x sample products, accumulates Num_coef of them and emits one

---
 rtl/fir_mac_datapath_pkg.sv | 29 ++
 rtl/fir_mac_datapath_if.sv | 33 +++
 rtl/fir_mac_datapath_coef_rom.sv | 25 ++
 rtl/fir_mac_datapath.sv | 149 ++++++++++++++
 tb/tb_fir_mac_datapath.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_mac_datapath_pkg.sv
// Shared definitions for the FIR MAC datapath: default geometry, a default
// coefficient image, the pipeline flag record and the address-width helper.
package fir_mac_datapath_pkg;

   localparam int DEF_NUM_COEF = 17;
   localparam int DEF_W_DATA   = 16;
   localparam int DEF_W_COEF   = 16;
   localparam int DEF_W_OUT    = 16;
   localparam int DEF_SHIFT    = 15;

   // Default tap image, tap 0 in the least significant word.
   localparam logic [DEF_NUM_COEF*DEF_W_COEF-1:0] DEF_COEF_INIT = {
      16'hFD00, 16'h0180, 16'h0500, 16'h0A00, 16'h1200, 16'h1C00,
      16'h2400, 16'h2C00, 16'h3000, 16'h2800, 16'h2000, 16'h1800,
      16'h1000, 16'h0900, 16'h0400, 16'h0100, 16'hFE00
   };

   // Tap-tracking flags that travel alongside the product and accumulator.
   typedef struct packed {
      logic last_p;   // product register holds the final tap
      logic last_a;   // accumulator has just absorbed the final tap
   } pipe_flags_t;

   // Width needed to index 'depth' entries (at least one bit).
   function automatic int addr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fir_mac_datapath_if.sv
// Sequencer-to-datapath bus of the FIR filter.
// Handshake: val_in qualifies data_in for exactly one cycle and there is no
// back-pressure; addr, ce_Reg, rst_Acc and ce_Acc are sampled on every rising
// edge as plain strobes; val_out qualifies data_out for exactly one cycle.
interface fir_mac_datapath_if #(
   parameter int Num_coef = 17,
   parameter int W_DATA   = 16,
   parameter int W_OUT    = 16
) ();
   import fir_mac_datapath_pkg::*;

   localparam int W_ADDR = addr_width(Num_coef);

   logic                     val_in;
   logic signed [W_DATA-1:0] data_in;
   logic [W_ADDR-1:0]        addr;
   logic                     ce_Reg;
   logic                     rst_Acc;
   logic                     ce_Acc;
   logic signed [W_OUT-1:0]  data_out;
   logic                     val_out;

   modport master (
      output val_in, data_in, addr, ce_Reg, rst_Acc, ce_Acc,
      input  data_out, val_out
   );

   modport slave (
      input  val_in, data_in, addr, ce_Reg, rst_Acc, ce_Acc,
      output data_out, val_out
   );

endinterface

// File: rtl/fir_mac_datapath_coef_rom.sv
// Coefficient LUT: Num_coef words of W_COEF bits taken from a parameter
// image, read combinationally. Addresses past the last tap read zero.
module fir_mac_datapath_coef_rom
   import fir_mac_datapath_pkg::*;
#(
   parameter int Num_coef = DEF_NUM_COEF,
   parameter int W_COEF   = DEF_W_COEF,
   parameter int W_ADDR   = addr_width(DEF_NUM_COEF),
   parameter logic [Num_coef*W_COEF-1:0] COEF_INIT = DEF_COEF_INIT
) (
   input  logic [W_ADDR-1:0]        i_addr,
   output logic signed [W_COEF-1:0] o_coef
);

   // Decode the tap index into its coefficient word.
   always_comb begin
      o_coef = '0;
      for (int k = 0; k < Num_coef; k++) begin
         if (i_addr == W_ADDR'(k)) begin
            o_coef = COEF_INIT[k*W_COEF +: W_COEF];
         end
      end
   end

endmodule

// File: rtl/fir_mac_datapath.sv
// Arithmetic half of the FIR filter: circular sample delay line, coefficient
// LUT, product register, accumulator and round/saturate output stage. Every
// step is driven by the sequencer strobes on the bus; nothing is decided here.
module fir_mac_datapath
   import fir_mac_datapath_pkg::*;
#(
   parameter int Num_coef = DEF_NUM_COEF,
   parameter int W_DATA   = DEF_W_DATA,
   parameter int W_COEF   = DEF_W_COEF,
   parameter int W_OUT    = DEF_W_OUT,
   parameter int SHIFT    = DEF_SHIFT,
   parameter logic [Num_coef*W_COEF-1:0] COEF_INIT = DEF_COEF_INIT
) (
   input  logic               clk,
   input  logic               rst,
   fir_mac_datapath_if.slave  bus
);

   localparam int W_ADDR = addr_width(Num_coef);
   localparam int W_PROD = W_DATA + W_COEF;
   // Wide enough that Num_coef full-scale products can never wrap.
   localparam int W_ACC  = W_PROD + W_ADDR;

   localparam logic [W_ADDR-1:0]        LAST_TAP = W_ADDR'(Num_coef - 1);
   localparam logic [W_ADDR:0]          DEPTH    = (W_ADDR + 1)'(Num_coef);
   localparam logic signed [W_ACC-1:0]  ROUND_K  = W_ACC'(1) << (SHIFT - 1);
   localparam logic signed [W_OUT-1:0]  OUT_MAX  = {1'b0, {(W_OUT-1){1'b1}}};
   localparam logic signed [W_OUT-1:0]  OUT_MIN  = {1'b1, {(W_OUT-1){1'b0}}};
   localparam logic signed [W_ACC-1:0]  ACC_MAX  = W_ACC'(OUT_MAX);
   localparam logic signed [W_ACC-1:0]  ACC_MIN  = W_ACC'(OUT_MIN);

   logic signed [W_DATA-1:0] r_dline [Num_coef];
   logic [W_ADDR-1:0]        r_wr_ptr;
   logic [W_ADDR-1:0]        r_newest;
   logic [W_ADDR-1:0]        r_base_ptr;
   logic signed [W_PROD-1:0] r_prod;
   logic signed [W_ACC-1:0]  r_acc;
   pipe_flags_t              r_flags;
   logic signed [W_OUT-1:0]  r_data_out;
   logic                     r_val_out;

   logic                     w_in_range;
   logic [W_ADDR-1:0]        w_rd_idx;
   logic signed [W_DATA-1:0] w_sample;
   logic signed [W_COEF-1:0] w_coef;
   logic signed [W_PROD-1:0] w_prod;
   logic signed [W_ACC-1:0]  w_rnd;
   logic signed [W_ACC-1:0]  w_shr;
   logic signed [W_OUT-1:0]  w_sat;

   fir_mac_datapath_coef_rom #(
      .Num_coef  (Num_coef),
      .W_COEF    (W_COEF),
      .W_ADDR    (W_ADDR),
      .COEF_INIT (COEF_INIT)
   ) u_coef_rom (
      .i_addr (bus.addr),
      .o_coef (w_coef)
   );

   // Sample read index (base - addr) mod depth, wrapped by compare/add so any depth works.
   always_comb begin
      w_in_range = ({1'b0, bus.addr} < DEPTH);
      if (r_base_ptr >= bus.addr) begin
         w_rd_idx = r_base_ptr - bus.addr;
      end else begin
         w_rd_idx = W_ADDR'(({1'b0, r_base_ptr} + DEPTH) - {1'b0, bus.addr});
      end
      w_sample = w_in_range ? r_dline[w_rd_idx] : '0;
   end

   // Full-width signed product; an out-of-range tap sees zero coefficient and zero sample.
   assign w_prod = $signed({{W_DATA{w_coef[W_COEF-1]}}, w_coef}) *
                   $signed({{W_COEF{w_sample[W_DATA-1]}}, w_sample});

   // Round half-up, arithmetic shift, then clamp to the output range.
   always_comb begin
      w_rnd = r_acc + ROUND_K;
      w_shr = w_rnd >>> SHIFT;
      if (w_shr > ACC_MAX) begin
         w_sat = OUT_MAX;
      end else if (w_shr < ACC_MIN) begin
         w_sat = OUT_MIN;
      end else begin
         w_sat = w_shr[W_OUT-1:0];
      end
   end

   // Delay line writes and the newest-sample snapshot taken on rst_Acc (with same-cycle bypass).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < Num_coef; i++) begin
            r_dline[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_newest   <= '0;
         r_base_ptr <= '0;
      end else begin
         if (bus.val_in) begin
            r_dline[r_wr_ptr] <= bus.data_in;
            r_newest          <= r_wr_ptr;
            r_wr_ptr          <= (r_wr_ptr == LAST_TAP) ? '0 : r_wr_ptr + 1'b1;
         end
         if (bus.rst_Acc) begin
            r_base_ptr <= bus.val_in ? r_wr_ptr : r_newest;
         end
      end
   end

   // Product and accumulator stages; rst_Acc overrides ce_Acc and kills the last-tap flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prod  <= '0;
         r_acc   <= '0;
         r_flags <= '0;
      end else begin
         if (bus.ce_Reg) begin
            r_prod         <= w_prod;
            r_flags.last_p <= (bus.addr == LAST_TAP);
         end
         if (bus.rst_Acc) begin
            r_acc          <= '0;
            r_flags.last_a <= 1'b0;
         end else if (bus.ce_Acc) begin
            r_acc          <= r_acc + W_ACC'(r_prod);
            r_flags.last_a <= r_flags.last_p;
         end else begin
            r_flags.last_a <= 1'b0;
         end
      end
   end

   // Output register: load the finished sum once per convolution and strobe val_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data_out <= '0;
         r_val_out  <= 1'b0;
      end else begin
         r_val_out <= r_flags.last_a;
         if (r_flags.last_a) begin
            r_data_out <= w_sat;
         end
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.val_out  = r_val_out;

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Bench for fir_mac_datapath: two instances (shaped taps and flat 0x0800
// taps) share one stimulus stream; a sample-history model computes each
// expected output directly from the convolution sum.
module tb_fir_mac_datapath;

   localparam int NC = 17;

   localparam logic [NC*16-1:0] COEFS_A = {
      16'hFD00, 16'h0180, 16'h0500, 16'h0A00, 16'h1200, 16'h1C00,
      16'h2400, 16'h2C00, 16'h3000, 16'h2800, 16'h2000, 16'h1800,
      16'h1000, 16'h0900, 16'h0400, 16'h0100, 16'hFE00
   };
   localparam logic [NC*16-1:0] COEFS_B = {NC{16'h0800}};

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fir_mac_datapath_if #(.Num_coef(NC), .W_DATA(16), .W_OUT(16)) bus_a ();
   fir_mac_datapath_if #(.Num_coef(NC), .W_DATA(16), .W_OUT(16)) bus_b ();

   assign bus_b.val_in  = bus_a.val_in;
   assign bus_b.data_in = bus_a.data_in;
   assign bus_b.addr    = bus_a.addr;
   assign bus_b.ce_Reg  = bus_a.ce_Reg;
   assign bus_b.rst_Acc = bus_a.rst_Acc;
   assign bus_b.ce_Acc  = bus_a.ce_Acc;

   fir_mac_datapath #(.Num_coef(NC), .W_DATA(16), .W_COEF(16), .W_OUT(16),
                      .SHIFT(15), .COEF_INIT(COEFS_A))
      dut_a (.clk(clk), .rst(rst_n), .bus(bus_a));

   fir_mac_datapath #(.Num_coef(NC), .W_DATA(16), .W_COEF(16), .W_OUT(16),
                      .SHIFT(15), .COEF_INIT(COEFS_B))
      dut_b (.clk(clk), .rst(rst_n), .bus(bus_b));

   // ---------------- model state / scoreboard ----------------
   int          coef_a [NC];
   int          coef_b [NC];
   int          hist[$];          // every sample written since reset, oldest first
   logic [15:0] exp_a_q[$];
   logic [15:0] exp_b_q[$];
   logic [15:0] got_a_q[$];
   logic [15:0] got_b_q[$];
   int          got_a_cyc[$];
   int          got_b_cyc[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // y[n] = sat(round(sum_k c[k]*x[n-k] / 2^15)); skipped tap contributes nothing.
   function automatic logic [15:0] model_out(input int sel, input int n, input int skip);
      longint      sum;
      longint      r;
      logic [63:0] rv;
      sum = 0;
      for (int k = 0; k < NC; k++) begin
         if (k != skip && n - k >= 0) begin
            sum += longint'((sel == 0) ? coef_a[k] : coef_b[k]) * longint'(hist[n-k]);
         end
      end
      r = (sum + 64'sd16384) >>> 15;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      rv = r;
      return rv[15:0];
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (bus_a.val_out) begin
         got_a_q.push_back(bus_a.data_out);
         got_a_cyc.push_back(cyc);
      end
      if (bus_b.val_out) begin
         got_b_q.push_back(bus_b.data_out);
         got_b_cyc.push_back(cyc);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] a,
                        input logic cr, input logic ra, input logic ca);
      bus_a.val_in  = v;
      bus_a.data_in = d;
      bus_a.addr    = a;
      bus_a.ce_Reg  = cr;
      bus_a.rst_Acc = ra;
      bus_a.ce_Acc  = ca;
   endtask

   task automatic write_gap(input logic [15:0] s);
      @(negedge clk);
      drive(1'b1, s, 5'd0, 1'b0, 1'b0, 1'b0);
      hist.push_back(int'($signed(s)));
   endtask

   // One sequencer pass: rst_Acc (optionally with a new sample), taps 0..NC-1,
   // then the trailing ce_Acc (with rst_Acc when aborting).
   task automatic run_seq(input bit use_val, input logic [15:0] sample, input int bad_tap,
                          input bit abort, output logic [15:0] out_a, output logic [15:0] out_b);
      int          c_last;
      int          n;
      logic [4:0]  a;
      out_a  = '0;
      out_b  = '0;
      c_last = 0;
      @(negedge clk);
      drive(use_val, sample, 5'd0, 1'b0, 1'b1, 1'b0);
      if (use_val) hist.push_back(int'($signed(sample)));
      n = hist.size() - 1;
      if (!abort) begin
         exp_a_q.push_back(model_out(0, n, bad_tap));
         exp_b_q.push_back(model_out(1, n, bad_tap));
      end
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         a = (k == bad_tap) ? 5'(17 + $urandom_range(0, 14)) : 5'(k);
         drive(1'b0, 16'h0, a, 1'b1, 1'b0, (k != 0));
         c_last = cyc;
      end
      @(negedge clk);
      drive(1'b0, 16'h0, 5'd0, 1'b0, abort, 1'b1);
      @(negedge clk);
      drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      if (abort) begin
         check("abort_cnt_a", got_a_q.size(), 0);
         check("abort_cnt_b", got_b_q.size(), 0);
      end else begin
         check("out_cnt_a", got_a_q.size(), 1);
         check("out_cnt_b", got_b_q.size(), 1);
         if (got_a_q.size() > 0) begin
            out_a = got_a_q[0];
            check("data_a", got_a_q[0], exp_a_q.pop_front());
            check("latency_a", got_a_cyc[0] - c_last, 3);
         end else begin
            void'(exp_a_q.pop_front());
         end
         if (got_b_q.size() > 0) begin
            out_b = got_b_q[0];
            check("data_b", got_b_q[0], exp_b_q.pop_front());
            check("latency_b", got_b_cyc[0] - c_last, 3);
         end else begin
            void'(exp_b_q.pop_front());
         end
      end
      got_a_q.delete();
      got_b_q.delete();
      got_a_cyc.delete();
      got_b_cyc.delete();
   endtask

   // Pull the async reset while tap 8 is in flight; the partial sum must vanish.
   task automatic run_reset_mid();
      @(negedge clk);
      drive(1'b1, 16'h1234, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         drive(1'b0, 16'h0, 5'(k), 1'b1, 1'b0, (k != 0));
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      hist.delete();
      repeat (4) @(negedge clk);
      #1;
      check("rst_mid_cnt_a", got_a_q.size(), 0);
      check("rst_mid_cnt_b", got_b_q.size(), 0);
      check("rst_mid_dout_a", bus_a.data_out, 0);
      check("rst_mid_dout_b", bus_b.data_out, 0);
      got_a_q.delete();
      got_b_q.delete();
      got_a_cyc.delete();
      got_b_cyc.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [NC*16-1:0] tmp_a;
      logic [NC*16-1:0] tmp_b;
      logic [15:0]      oa;
      logic [15:0]      ob;
      logic [15:0]      s;
      int               sel;

      tmp_a = COEFS_A;
      tmp_b = COEFS_B;
      for (int k = 0; k < NC; k++) begin
         coef_a[k] = int'($signed(tmp_a[k*16 +: 16]));
         coef_b[k] = int'($signed(tmp_b[k*16 +: 16]));
      end

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("reset_dout_a", bus_a.data_out, 0);
      check("reset_dout_b", bus_b.data_out, 0);
      check("reset_val_a", bus_a.val_out, 0);
      check("reset_val_b", bus_b.val_out, 0);

      // Impulse: one full-scale sample then zeros walks the taps out in order.
      run_seq(1'b1, 16'h7FFF, -1, 1'b0, oa, ob);
      for (int i = 0; i < NC - 1; i++) run_seq(1'b1, 16'h0000, -1, 1'b0, oa, ob);

      // Step: flat taps of 0x0800 settle at 17*0x4000*0x0800>>>15.
      for (int i = 0; i < NC; i++) run_seq(1'b1, 16'h4000, -1, 1'b0, oa, ob);
      check("step_final_b", ob, 16'h4400);

      // Saturation both ways.
      for (int i = 0; i < NC; i++) run_seq(1'b1, 16'h7FFF, -1, 1'b0, oa, ob);
      check("sat_pos_a", oa, 16'h7FFF);
      check("sat_pos_b", ob, 16'h7FFF);
      for (int i = 0; i < NC; i++) run_seq(1'b1, 16'h8000, -1, 1'b0, oa, ob);
      check("sat_neg_a", oa, 16'h8000);
      check("sat_neg_b", ob, 16'h8000);

      // Ramp across several write-pointer wraps.
      for (int i = 1; i <= 3 * NC + 5; i++) run_seq(1'b1, 16'(i), -1, 1'b0, oa, ob);

      // Randomized mix: gap writes, bypass writes, out-of-range taps, aborts.
      for (int i = 0; i < 30; i++) begin
         sel = int'($urandom_range(0, 3));
         s   = 16'($urandom_range(0, 65535));
         case (sel)
            0: begin
               write_gap(s);
               write_gap(16'($urandom_range(0, 65535)));
               run_seq(1'b0, 16'h0, -1, 1'b0, oa, ob);
            end
            1: run_seq(1'b1, s, -1, 1'b0, oa, ob);
            2: run_seq(1'b1, s, int'($urandom_range(0, NC - 2)), 1'b0, oa, ob);
            default: run_seq(1'b1, s, -1, 1'b1, oa, ob);
         endcase
      end

      // Abort via rst_Acc on the final ce_Acc, then a clean pass.
      run_seq(1'b1, 16'h2345, -1, 1'b1, oa, ob);
      run_seq(1'b1, 16'h0F0F, -1, 1'b0, oa, ob);

      // Async reset mid-convolution, then only coef[0]*x remains.
      run_reset_mid();
      run_seq(1'b1, 16'h5A5A, -1, 1'b0, oa, ob);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
